// File: rtl/fetch_pkg.sv
// Shared constants and next-PC select encoding for the instruction-fetch stage.
package fetch_pkg;

    localparam int ADDR_W = 8;
    localparam int INST_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_HOLD
    } fetch_sel_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: InstMemory address/data, redirect/stall controls and the IF/ID register outputs.
interface fetch_if;
    import fetch_pkg::*;

    logic [ADDR_W-1:0] instAddr;
    logic [INST_W-1:0] instruction;
    logic              stall;
    logic              branchTaken;
    logic [ADDR_W-1:0] branchTarget;
    logic              jump;
    logic [ADDR_W-1:0] jumpTarget;
    logic [INST_W-1:0] ifidInstr;
    logic [ADDR_W-1:0] ifidPcPlus4;
    logic              ifidValid;
    logic              alignErr;

    // No ready back-pressure here: stall freezes the stage, and ifidValid=0 marks a bubble that decode must ignore.
    modport master (
        output instAddr, ifidInstr, ifidPcPlus4, ifidValid, alignErr,
        input  instruction, stall, branchTaken, branchTarget, jump, jumpTarget
    );

    modport slave (
        input  instAddr, ifidInstr, ifidPcPlus4, ifidValid, alignErr,
        output instruction, stall, branchTaken, branchTarget, jump, jumpTarget
    );

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: branch > jump > stall > sequential, with target alignment.
// FETCH_ALIGN_CHECK_EN: misaligned redirect targets fall through to PC+4 and raise misaligned.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchTarget,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jumpTarget,
    output fetch_sel_t        sel,
    output logic [ADDR_W-1:0] pcPlus4,
    output logic [ADDR_W-1:0] nextPc
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic              misaligned
`endif
);

    logic [ADDR_W-1:0] target;

    assign pcPlus4 = pc + ADDR_W'(4);

    // A redirect outranks stall because the stalled ID instruction is on the wrong path.
    always_comb begin
        sel    = SEL_SEQ;
        target = jumpTarget;
        if (branchTaken) begin
            sel    = SEL_BRANCH;
            target = branchTarget;
        end else if (jump) begin
            sel    = SEL_JUMP;
        end else if (stall) begin
            sel    = SEL_HOLD;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = ((sel == SEL_BRANCH) || (sel == SEL_JUMP)) && (target[1:0] != 2'b00);

    always_comb begin
        nextPc = pcPlus4;
        case (sel)
            SEL_HOLD:            nextPc = pc;
            SEL_BRANCH, SEL_JUMP: nextPc = misaligned ? pcPlus4 : target;
            default:             nextPc = pcPlus4;
        endcase
    end
`else
    always_comb begin
        nextPc = pcPlus4;
        case (sel)
            SEL_HOLD:            nextPc = pc;
            SEL_BRANCH, SEL_JUMP: nextPc = target & ~ADDR_W'(3);
            default:             nextPc = pcPlus4;
        endcase
    end
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and the sticky alignErr flag.
// FETCH_ALIGN_CHECK_EN enables misaligned-redirect detection; otherwise alignErr is constant 0.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pcPlus4;
    logic [ADDR_W-1:0] nextPc;
    fetch_sel_t        sel;
    logic [INST_W-1:0] ifidInstr;
    logic [ADDR_W-1:0] ifidPcPlus4;
    logic              ifidValid;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    logic alignErr;
`endif

    fetch_next_pc uNextPc (
        .pc           (pc),
        .stall        (bus.stall),
        .branchTaken  (bus.branchTaken),
        .branchTarget (bus.branchTarget),
        .jump         (bus.jump),
        .jumpTarget   (bus.jumpTarget),
        .sel          (sel),
        .pcPlus4      (pcPlus4),
        .nextPc       (nextPc)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misaligned   (misaligned)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= nextPc;
        end
    end

    // A flush keeps ifidPcPlus4 as-is; only the instruction word and valid bit are bubbled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifidInstr   <= NOP_INST;
            ifidPcPlus4 <= '0;
            ifidValid   <= 1'b0;
        end else begin
            case (sel)
                SEL_SEQ: begin
                    ifidInstr   <= bus.instruction;
                    ifidPcPlus4 <= pcPlus4;
                    ifidValid   <= 1'b1;
                end
                SEL_BRANCH, SEL_JUMP: begin
                    ifidInstr   <= NOP_INST;
                    ifidValid   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alignErr <= 1'b0;
        end else if (misaligned) begin
            alignErr <= 1'b1;
        end
    end
    assign bus.alignErr = alignErr;
`else
    assign bus.alignErr = 1'b0;
`endif

    assign bus.instAddr    = pc;
    assign bus.ifidInstr   = ifidInstr;
    assign bus.ifidPcPlus4 = ifidPcPlus4;
    assign bus.ifidValid   = ifidValid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences, randomized run vs. model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_if bus ();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  assign bus.instruction = mem[bus.instAddr[7:2]];

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_pc, m_p4, m_valid, m_err;
  logic [31:0] m_instr;

  typedef struct {
    logic        stall;
    logic        br;
    logic        jmp;
    logic [7:0]  brT;
    logic [7:0]  jmpT;
    logic [7:0]  expPc;
    logic [31:0] expInstr;
    logic [7:0]  expP4;
    logic        expValid;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [31:0] word(int a);
    return 32'hAB00_0000 | 32'(a);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic s, logic b, logic [7:0] bt, logic j, logic [7:0] jt);
    bus.stall        = s;
    bus.branchTaken  = b;
    bus.branchTarget = bt;
    bus.jump         = j;
    bus.jumpTarget   = jt;
  endtask

  task automatic check_outputs(string tag, logic [7:0] pc, logic [31:0] instr,
                               logic [7:0] p4, logic valid, logic err);
    check({tag, ".instAddr"},    32'(bus.instAddr),    32'(pc));
    check({tag, ".ifidInstr"},   bus.ifidInstr,        instr);
    check({tag, ".ifidPcPlus4"}, 32'(bus.ifidPcPlus4), 32'(p4));
    check({tag, ".ifidValid"},   32'(bus.ifidValid),   32'(valid));
    check({tag, ".alignErr"},    32'(bus.alignErr),    32'(err));
  endtask

  task automatic model_reset();
    m_pc = 0; m_p4 = 0; m_valid = 0; m_err = 0; m_instr = 32'h0;
  endtask

  // Applies the stage rules to the current inputs; call before the edge.
  task automatic model_step();
    int tgt;
    if (bus.branchTaken || bus.jump) begin
      tgt = bus.branchTaken ? int'(bus.branchTarget) : int'(bus.jumpTarget);
`ifdef FETCH_ALIGN_CHECK_EN
      if (tgt % 4 != 0) begin
        m_pc  = (m_pc + 4) % 256;
        m_err = 1;
      end else begin
        m_pc = tgt;
      end
`else
      m_pc = tgt - (tgt % 4);
`endif
      m_instr = 32'h0;
      m_valid = 0;
    end else if (!bus.stall) begin
      m_instr = mem[m_pc / 4];
      m_p4    = (m_pc + 4) % 256;
      m_pc    = m_p4;
      m_valid = 1;
    end
  endtask

  task automatic check_model(string tag);
    check_outputs(tag, 8'(m_pc), m_instr, 8'(m_p4), 1'(m_valid), 1'(m_err));
  endtask

  initial begin
    logic align;
    for (int i = 0; i < 64; i++) mem[i] = word(i * 4);
    drive(0, 0, 8'h00, 0, 8'h00);

`ifdef FETCH_ALIGN_CHECK_EN
    align = 1'b1;
`else
    align = 1'b0;
`endif

    //           stall br jmp brT    jmpT   expPc  expInstr     expP4  expValid
    vecs[0]  = '{0, 0, 0, 8'h00, 8'h00, 8'h04, word(8'h00), 8'h04, 1};
    vecs[1]  = '{0, 0, 0, 8'h00, 8'h00, 8'h08, word(8'h04), 8'h08, 1};
    vecs[2]  = '{1, 0, 0, 8'h00, 8'h00, 8'h08, word(8'h04), 8'h08, 1};
    vecs[3]  = '{1, 0, 0, 8'h00, 8'h00, 8'h08, word(8'h04), 8'h08, 1};
    vecs[4]  = '{0, 0, 0, 8'h00, 8'h00, 8'h0C, word(8'h08), 8'h0C, 1};
    vecs[5]  = '{1, 1, 1, 8'h40, 8'h80, 8'h40, 32'h0,       8'h0C, 0};
    vecs[6]  = '{0, 0, 0, 8'h00, 8'h00, 8'h44, word(8'h40), 8'h44, 1};
    vecs[7]  = '{0, 0, 1, 8'h00, 8'h80, 8'h80, 32'h0,       8'h44, 0};
    vecs[8]  = '{0, 0, 0, 8'h00, 8'h00, 8'h84, word(8'h80), 8'h84, 1};
    vecs[9]  = '{0, 1, 0, 8'hFC, 8'h00, 8'hFC, 32'h0,       8'h84, 0};
    vecs[10] = '{0, 0, 0, 8'h00, 8'h00, 8'h00, word(8'hFC), 8'h00, 1};
    vecs[11] = '{0, 0, 0, 8'h00, 8'h00, 8'h04, word(8'h00), 8'h04, 1};
    vecs[12] = '{1, 0, 1, 8'h00, 8'h10, 8'h10, 32'h0,       8'h04, 0};
    vecs[13] = '{1, 0, 0, 8'h00, 8'h00, 8'h10, 32'h0,       8'h04, 0};
    vecs[14] = '{0, 0, 0, 8'h00, 8'h00, 8'h14, word(8'h10), 8'h14, 1};

    // clock/reset
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 8'h00, 32'h0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("reset_release.instAddr", 32'(bus.instAddr), 32'h00);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].brT, vecs[i].jmp, vecs[i].jmpT);
      tick();
      check_outputs($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expInstr,
                    vecs[i].expP4, vecs[i].expValid, 1'b0);
    end

    // misaligned jump at PC=0x10
    drive(0, 0, 8'h00, 1, 8'h10);
    tick();
    check_outputs("jmp10", 8'h10, 32'h0, 8'h14, 1'b0, 1'b0);
    drive(0, 0, 8'h00, 1, 8'h42);
    tick();
    if (align) check_outputs("misjmp", 8'h14, 32'h0, 8'h14, 1'b0, 1'b1);
    else       check_outputs("misjmp", 8'h40, 32'h0, 8'h14, 1'b0, 1'b0);
    drive(0, 0, 8'h00, 0, 8'h00);
    tick();
    if (align) check_outputs("misjmp_after", 8'h18, word(8'h14), 8'h18, 1'b1, 1'b1);
    else       check_outputs("misjmp_after", 8'h44, word(8'h40), 8'h44, 1'b1, 1'b0);
    drive(1, 0, 8'h00, 0, 8'h00);
    tick();
    check("sticky.alignErr", 32'(bus.alignErr), 32'(align));

    // async reset in the middle of a redirect cycle
    drive(0, 1, 8'h80, 0, 8'h00);
    #2 rst = 1'b1;
    #1;
    check_outputs("midrst", 8'h00, 32'h0, 8'h00, 1'b0, 1'b0);
    tick();
    check("midrst_held.instAddr", 32'(bus.instAddr), 32'h00);
    drive(0, 0, 8'h00, 0, 8'h00);
    rst = 1'b0;
    model_reset();
    model_step();
    tick();
    check_model("resume");

    // randomized run against the model
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    for (int n = 0; n < 400; n++) begin
      logic [7:0] bt, jt;
      bt = 8'($urandom_range(0, 255));
      jt = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) bt = bt & 8'hFC;
      if ($urandom_range(0, 1) == 0) jt = jt & 8'hFC;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, bt,
            $urandom_range(0, 7) == 0, jt);
      if ($urandom_range(0, 63) == 0) begin
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_model($sformatf("rnd_rst%0d", n));
        rst = 1'b0;
      end
      model_step();
      tick();
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
